conv_encoder_k4: RTL and testbench



---
 rtl/conv_encoder_k4.sv | 163 ++++++++++++++++
 tb/tb_conv_encoder_k4.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_k4.sv
// conv_encoder_k4 -- rate-1/2, K=4 convolutional encoder with trellis
// termination. Information bits are grouped into frames of FRAME_LEN bits.
// Each frame is followed by three zero tail bits, which return the encoder
// state to 000.
//
// Optional build macro: CONV_PUNCTURE_EN.
//   Defined   : rate-2/3 puncturing. Odd-index information symbols carry
//               out_keep=10. Even-index and tail symbols carry out_keep=11.
//   Undefined : out_keep is 11 on every valid symbol.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both high. The producer holds valid and data stable until the
// transfer. On this block, in_ready is asserted only when the output slot is
// free (!out_valid || out_ready) and the FSM is in DATA. While out_valid is
// high and out_ready is low, nothing inside the encoder advances.
//
// Debug: state_out shows the shift register sr[2:0]. fsm_q selects DATA or
// TAIL, and the current tail step is held in tcnt_q.
module conv_encoder_k4 #(
  parameter logic [3:0] G0        = 4'b1101,
  parameter logic [3:0] G1        = 4'b1111,
  parameter int         FRAME_LEN = 64,
  parameter int         CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic [1:0] out_keep,
  output logic       out_last,
  output logic [2:0] state_out
);

  localparam logic [0:0]       ST_DATA   = 1'b0;
  localparam logic [0:0]       ST_TAIL   = 1'b1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [1:0]       TCNT_LAST = 2'd2;

  logic [0:0]       fsm_q, fsm_d;
  logic [2:0]       sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tcnt_q, tcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic [1:0]       out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;

  logic             slot_free;
  logic             data_take;
  logic             tail_step;
  logic             load;
  logic             u;
  logic [3:0]       tap;
  logic             c0;
  logic             c1;
  logic [1:0]       keep_new;

  // Handshake qualifiers and the encoder input bit for this cycle.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = (fsm_q == ST_DATA) && slot_free;
    data_take = in_valid && in_ready;
    tail_step = (fsm_q == ST_TAIL) && slot_free;
    load      = data_take || tail_step;
    // Tail steps always feed a zero into the trellis.
    u         = tail_step ? 1'b0 : in_bit;
  end

  // Code bits: generator taps in the order {u, sr[0], sr[1], sr[2]}.
  always_comb begin
    tap = {u, sr_q[0], sr_q[1], sr_q[2]};
    c0  = ^(G0 & tap);
    c1  = ^(G1 & tap);
  end

  // Transmit mask for the symbol being loaded.
  always_comb begin
`ifdef CONV_PUNCTURE_EN
    // Drop c1 on odd-index information bits. Tail symbols are never punctured.
    keep_new = (data_take && cnt_q[0]) ? 2'b10 : 2'b11;
`else
    keep_new = 2'b11;
`endif
  end

  // Next-state logic for the FSM, the counters and the trellis register.
  always_comb begin
    fsm_d  = fsm_q;
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    tcnt_d = tcnt_q;
    if (load) begin
      sr_d = {sr_q[1:0], u};
    end
    if (data_take) begin
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
        fsm_d = ST_TAIL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (tail_step) begin
      if (tcnt_q == TCNT_LAST) begin
        tcnt_d = 2'd0;
        fsm_d  = ST_DATA;
      end else begin
        tcnt_d = tcnt_q + 2'd1;
      end
    end
  end

  // Output register: a load replaces the held symbol, and a take without a load empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_sym_d   = {c0, c1};
      out_keep_d  = keep_new;
      out_last_d  = tail_step && (tcnt_q == TCNT_LAST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State registers with synchronous reset. Reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_DATA;
      sr_q        <= 3'b000;
      cnt_q       <= '0;
      tcnt_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_keep_q  <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign state_out = sr_q;

endmodule

// File: tb/tb_conv_encoder_k4.sv
// tb_conv_encoder_k4 -- directed bench for conv_encoder_k4 with FRAME_LEN=4.
// The expected symbol stream is computed per frame from the code definition:
// c0 = x[n]^x[n-1]^x[n-3], c1 = x[n]^x[n-1]^x[n-2]^x[n-3].
// Here x is the frame's information bits followed by three zeros. Samples
// before the frame start are taken as zero.
module tb_conv_encoder_k4;

  localparam int FL = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_sym;
  logic [1:0] out_keep;
  logic       out_last;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  conv_encoder_k4 #(
    .G0(4'b1101), .G1(4'b1111), .FRAME_LEN(FL), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_keep(out_keep), .out_last(out_last),
    .state_out(state_out)
  );

  // ---------------- bookkeeping ----------------
  int         checks = 0;
  int         failures = 0;
  logic [4:0] exp_q[$];        // {last, keep[1:0], sym[1:0]}
  logic [4:0] e;
  int         xfer_cnt = 0;
  logic       gap_en = 1'b0;
  int         gap_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [1:0] prev_sym;
  logic [1:0] prev_keep;
  logic       prev_last;
  logic [2:0] prev_state;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [13:0] model_syms(input logic [3:0] b);
    logic [6:0]  x;
    logic [13:0] r;
    logic        xm1, xm2, xm3;
    x = {3'b000, b};
    r = '0;
    for (int i = 0; i < 7; i++) begin
      xm1 = (i >= 1) ? x[i-1] : 1'b0;
      xm2 = (i >= 2) ? x[i-2] : 1'b0;
      xm3 = (i >= 3) ? x[i-3] : 1'b0;
      r[13-2*i -: 2] = {x[i] ^ xm1 ^ xm3, x[i] ^ xm1 ^ xm2 ^ xm3};
    end
    return r;
  endfunction

  function automatic logic [1:0] model_keep(input int i);
`ifdef CONV_PUNCTURE_EN
    return (i < FL && (i % 2) == 1) ? 2'b10 : 2'b11;
`else
    return 2'b11;
`endif
  endfunction

  task automatic build_frame(input logic [3:0] b);
    logic [13:0] s;
    s = model_syms(b);
    for (int i = 0; i < 7; i++)
      exp_q.push_back({(i == 6), model_keep(i), s[13-2*i -: 2]});
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sym actual=%0h required=none", out_sym);
        end else begin
          e = exp_q.pop_front();
          check("sym", 16'(out_sym), 16'(e[1:0]));
          check("keep", 16'(out_keep), 16'(e[3:2]));
          check("last", 16'(out_last), 16'(e[4]));
          if (out_last) check("state_after_tail", 16'(state_out), 16'd0);
        end
      end
      if (out_valid && !out_ready) check("in_ready_bp", 16'(in_ready), 16'd0);
      if (prev_hold) begin
        check("hold_valid", 16'(out_valid), 16'd1);
        check("hold_sym", 16'(out_sym), 16'(prev_sym));
        check("hold_keep", 16'(out_keep), 16'(prev_keep));
        check("hold_last", 16'(out_last), 16'(prev_last));
        check("hold_state", 16'(state_out), 16'(prev_state));
      end
      prev_hold  = out_valid && !out_ready;
      prev_sym   = out_sym;
      prev_keep  = out_keep;
      prev_last  = out_last;
      prev_state = state_out;
    end else begin
      prev_hold = 1'b0;
    end
    if (gap_en && !in_ready) gap_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_bit = b;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end else begin
      check("latency_valid", 16'(out_valid), 16'd1);
      check("sr0_new_bit", 16'(state_out[0]), 16'(b));
    end
  endtask

  task automatic send_frame(input logic [3:0] b);
    for (int i = 0; i < FL; i++) send_bit(b[i]);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue", 16'(exp_q.size()), 16'd0);
    check("drain_valid", 16'(out_valid), 16'd0);
    check("drain_state", 16'(state_out), 16'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    logic reached;
    logic [13:0] kp;

    // Hand-computed literals that pin the model itself.
    check("model_impulse", 16'(model_syms(4'b0001)), 16'(14'b11110111000000));
    check("model_all_ones", 16'(model_syms(4'b1111)), 16'(14'b11000110011011));
    kp = '0;
    for (int i = 0; i < 7; i++) kp[13-2*i -: 2] = model_keep(i);
`ifdef CONV_PUNCTURE_EN
    check("model_keep", 16'(kp), 16'(14'b11101110111111));
`else
    check("model_keep", 16'(kp), 16'(14'b11111111111111));
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_state", 16'(state_out), 16'd0);
    check("rst_keep", 16'(out_keep), 16'd0);
    check("rst_sym", 16'(out_sym), 16'd0);
    check("rst_last", 16'(out_last), 16'd0);
    @(posedge clk);
    #1;

    // Impulse frame.
    build_frame(4'b0001);
    send_frame(4'b0001);
    in_valid = 1'b0;
    drain();

    // All-ones frame.
    build_frame(4'b1111);
    send_frame(4'b1111);
    in_valid = 1'b0;
    drain();

    // Back-pressure after the 2nd symbol.
    build_frame(4'b0110);
    base = xfer_cnt;
    fork
      send_frame(4'b0110);
      begin
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
          @(posedge clk);
          #1;
          reached = (xfer_cnt >= base + 2);
        end
        if (!reached) begin
          checks++;
          failures++;
          $display("FAIL bp_wait actual=%0d required=%0d", xfer_cnt - base, 2);
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    // Back-to-back frames with in_valid held high.
    build_frame(4'b1101);
    build_frame(4'b1010);
    build_frame(4'b0011);
    gap_cnt = 0;
    send_bit(1'b1);
    gap_en = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(4'b1010);
    send_frame(4'b0011);
    gap_en = 1'b0;
    check("tail_gap_cycles", 16'(gap_cnt), 16'd6);
    in_valid = 1'b0;
    drain();

    // Reset mid-frame while a symbol is held.
    build_frame(4'b0111);
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_rst_valid", 16'(out_valid), 16'd1);
    out_ready = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_state", 16'(state_out), 16'd0);
    check("mid_rst_keep", 16'(out_keep), 16'd0);
    check("mid_rst_last", 16'(out_last), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    build_frame(4'b0001);
    send_frame(4'b0001);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
